// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared calculator ALU constants and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int CALC_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } calc_state_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/twos_negate.sv
`default_nettype none
// ============================================================================
// Module      : twos_negate
// Description : Conditional two's-complement negate, shared across ALU blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module twos_negate #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_negate ? ({WIDTH{1'b0}} - i_value) : i_value;

endmodule : twos_negate
`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_multiplier
// Description : Sequential shift-and-add multiplier, one partial product per
//               clock, signed/unsigned, start/done handshake, held result.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_add_multiplier
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    calc_state_t          r_state;
    calc_state_t          w_state_next;

    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic [WIDTH-1:0]     r_acc;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_neg;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_start_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_signed_prod;

    // Magnitudes only when signed; the most-negative value maps onto itself,
    // which is exactly its unsigned magnitude.
    twos_negate #(.WIDTH(WIDTH)) u_abs_a (
        .i_value  (A),
        .i_negate (signed_mode & A[WIDTH-1]),
        .o_value  (w_abs_a)
    );

    twos_negate #(.WIDTH(WIDTH)) u_abs_b (
        .i_value  (B),
        .i_negate (signed_mode & B[WIDTH-1]),
        .o_value  (w_abs_b)
    );

    twos_negate #(.WIDTH(2*WIDTH)) u_prod_sign (
        .i_value  (w_prod),
        .i_negate (r_neg),
        .o_value  (w_signed_prod)
    );

    assign w_start_accept = (r_state == ST_IDLE) && start;
    assign w_last         = (r_state == ST_RUN) && (r_count == c_CNT_ONE);

    // Carry-extended partial-product add, then {carry, acc, mag_b} >> 1.
    // r_mag_b[0] has been consumed, so only the upper multiplier bits survive.
    assign w_sum  = {1'b0, r_acc} + (r_mag_b[0] ? {1'b0, r_mag_a} : {(WIDTH+1){1'b0}});
    assign w_prod = {w_sum, r_mag_b[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_IDLE;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start_accept) begin
                r_mag_a <= w_abs_a;
                r_mag_b <= w_abs_b;
                r_neg   <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                r_acc   <= '0;
                r_count <= c_CNT_INIT;
            end else if (r_state == ST_RUN) begin
                r_acc   <= w_prod[2*WIDTH-1:WIDTH];
                r_mag_b <= w_prod[WIDTH-1:0];
                r_count <= r_count - c_CNT_ONE;
                if (w_last) begin
                    r_p    <= w_signed_prod;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign P    = r_p;

endmodule : seq_shift_add_multiplier
`default_nettype wire
